mmio_initiator: RTL and testbench

Requester side of the PVALID/PREADY MMIO bus. Accepts one load/store at a time from an upstream valid/ready port, drives PVALID/PADDR/PWRITE/PWDATA until the device answers with PREADY, captures PRDATA, and returns a response on a valid/ready port. A programmable timeout closes transfers to devices that never answer, so a missing device cannot hang the core.

---
 rtl/mmio_initiator.sv | 100 ++++++++++
 tb/tb_mmio_initiator.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mmio_initiator.sv
// Requester side of the PVALID/PREADY MMIO bus: one load/store at a time,
// with a programmable timeout so an absent device cannot stall the core.
module mmio_initiator #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 256
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_write,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              PVALID,
  output logic [ADDR_W-1:0] PADDR,
  output logic              PWRITE,
  output logic [DATA_W-1:0] PWDATA,
  input  logic              PREADY,
  input  logic [DATA_W-1:0] PRDATA,
  output logic [1:0]        dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // Once valid is raised, it and its payload stay stable until that edge.
  // On the bus side PVALID drops on the edge that samples PREADY=1.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam int unsigned CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CNT_W-1:0] CNT_LAST = LAST_I[CNT_W-1:0];
  localparam bit TO_EN = (TIMEOUT != 0);

  state_t           state;
  logic [CNT_W-1:0] cnt;

  assign req_ready = (state == IDLE);
  assign dbg_state = state;

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state     <= IDLE;
      cnt       <= '0;
      PVALID    <= 1'b0;
      PADDR     <= '0;
      PWRITE    <= 1'b0;
      PWDATA    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            PADDR  <= req_addr;
            PWRITE <= req_write;
            PWDATA <= req_wdata;
            PVALID <= 1'b1;
            cnt    <= '0;
            state  <= ACCESS;
          end
        end
        ACCESS: begin
          // A device answer on the limit cycle still counts as success.
          if (PREADY) begin
            PVALID    <= 1'b0;
            rsp_rdata <= PWRITE ? '0 : PRDATA;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else if (TO_EN && (cnt == CNT_LAST)) begin
            PVALID    <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else if (TO_EN) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_initiator.sv
// Bench for mmio_initiator: two instances (long and short timeout) share one
// stimulus path selected by `sel`; expected responses come from a transfer model.
module tb_mmio_initiator;

  localparam int T_LONG  = 16;
  localparam int T_SHORT = 4;

  // clock/reset
  logic PCLK;
  logic PRESETn;
  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  logic        sel;
  logic        req_valid, req_write, rsp_ready, PREADY;
  logic [31:0] req_addr, req_wdata, PRDATA;

  logic        req_ready_l, rsp_valid_l, rsp_err_l, pvalid_l, pwrite_l;
  logic [31:0] rsp_rdata_l, paddr_l, pwdata_l;
  logic [1:0]  dbg_l;
  logic        req_ready_s, rsp_valid_s, rsp_err_s, pvalid_s, pwrite_s;
  logic [31:0] rsp_rdata_s, paddr_s, pwdata_s;
  logic [1:0]  dbg_s;

  mmio_initiator #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(T_LONG)) dut_long (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid & ~sel), .req_ready(req_ready_l),
    .req_addr(req_addr), .req_write(req_write), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_l), .rsp_ready(rsp_ready & ~sel),
    .rsp_rdata(rsp_rdata_l), .rsp_err(rsp_err_l),
    .PVALID(pvalid_l), .PADDR(paddr_l), .PWRITE(pwrite_l), .PWDATA(pwdata_l),
    .PREADY(PREADY & ~sel), .PRDATA(PRDATA), .dbg_state(dbg_l)
  );

  mmio_initiator #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(T_SHORT)) dut_short (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid & sel), .req_ready(req_ready_s),
    .req_addr(req_addr), .req_write(req_write), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_s), .rsp_ready(rsp_ready & sel),
    .rsp_rdata(rsp_rdata_s), .rsp_err(rsp_err_s),
    .PVALID(pvalid_s), .PADDR(paddr_s), .PWRITE(pwrite_s), .PWDATA(pwdata_s),
    .PREADY(PREADY & sel), .PRDATA(PRDATA), .dbg_state(dbg_s)
  );

  wire        o_req_ready = sel ? req_ready_s : req_ready_l;
  wire        o_rsp_valid = sel ? rsp_valid_s : rsp_valid_l;
  wire        o_rsp_err   = sel ? rsp_err_s   : rsp_err_l;
  wire [31:0] o_rsp_rdata = sel ? rsp_rdata_s : rsp_rdata_l;
  wire        o_pvalid    = sel ? pvalid_s    : pvalid_l;
  wire        o_pwrite    = sel ? pwrite_s    : pwrite_l;
  wire [31:0] o_paddr     = sel ? paddr_s     : paddr_l;
  wire [31:0] o_pwdata    = sel ? pwdata_s    : pwdata_l;

  // scoreboard
  logic [32:0] exp_q[$];
  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input logic [63:0] obs, input logic [63:0] exp, input string tag);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: the device answers in PVALID cycle d (0 = never).
  // Success if it answers within the timeout window, else error after T cycles.
  task automatic model(input int t, input int d, input logic w, input logic [31:0] rd,
                       output int pv_cycles, output logic [32:0] rsp);
    if (d != 0 && (t == 0 || d <= t)) begin
      pv_cycles = d;
      rsp = {1'b0, (w ? 32'h0 : rd)};
    end else begin
      pv_cycles = t;
      rsp = {1'b1, 32'h0};
    end
  endtask

  // driver: called at posedge+1 with the selected DUT idle
  task automatic run_txn(input logic [31:0] a, input logic w, input logic [31:0] wd,
                         input logic [31:0] rd, input int d, input int rsp_wait,
                         input string tag);
    int          t, pv_cycles, ci;
    logic [32:0] exp_rsp, got;
    t = sel ? T_SHORT : T_LONG;
    model(t, d, w, rd, pv_cycles, exp_rsp);
    exp_q.push_back(exp_rsp);
    req_valid = 1'b1; req_addr = a; req_write = w; req_wdata = wd; PRDATA = rd;
    rsp_ready = 1'b0; PREADY = 1'b0;
    @(negedge PCLK);
    chk(64'(o_req_ready), 64'(1'b1), {tag, "_req_ready_idle"});
    chk(64'(o_rsp_valid), 64'(1'b0), {tag, "_rsp_valid_idle"});
    chk(64'(o_pvalid), 64'(1'b0), {tag, "_pvalid_idle"});
    @(posedge PCLK); #1;
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_write = ~w;
    for (int k = 1; k <= pv_cycles; k++) begin
      PREADY = (k == d);
      @(negedge PCLK);
      chk(64'(o_pvalid), 64'(1'b1), {tag, "_pvalid_high"});
      chk(64'(o_paddr), 64'(a), {tag, "_paddr"});
      chk(64'(o_pwrite), 64'(w), {tag, "_pwrite"});
      chk(64'(o_pwdata), 64'(wd), {tag, "_pwdata"});
      chk(64'(o_req_ready), 64'(1'b0), {tag, "_req_ready_access"});
      chk(64'(o_rsp_valid), 64'(1'b0), {tag, "_rsp_valid_access"});
      @(posedge PCLK); #1;
      PREADY = 1'b0;
    end
    got = exp_q.pop_front();
    for (int k = 0; k <= rsp_wait; k++) begin
      ci = pv_cycles + 1 + k;
      PREADY = (d != 0 && ci == d);
      rsp_ready = (k == rsp_wait);
      req_valid = 1'b1; req_addr = $urandom;
      @(negedge PCLK);
      chk(64'(o_pvalid), 64'(1'b0), {tag, "_pvalid_resp"});
      chk(64'(o_rsp_valid), 64'(1'b1), {tag, "_rsp_valid"});
      chk(64'({o_rsp_err, o_rsp_rdata}), 64'(got), {tag, "_rsp_err_rdata"});
      chk(64'(o_req_ready), 64'(1'b0), {tag, "_req_ready_resp"});
      @(posedge PCLK); #1;
    end
    PREADY = 1'b0; rsp_ready = 1'b0; req_valid = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int          d, rw, t;
    logic        w;
    logic [31:0] a, wd, rd;

    sel = 1'b0; PRESETn = 1'b0; req_valid = 1'b1; req_addr = 32'h0000_0040;
    req_write = 1'b1; req_wdata = 32'h1111_1111; rsp_ready = 1'b0;
    PREADY = 1'b0; PRDATA = 32'h0;

    // reset with req_valid held high
    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    chk(64'(pvalid_l), 64'(1'b0), "rst_pvalid");
    chk(64'(rsp_valid_l), 64'(1'b0), "rst_rsp_valid");
    chk(64'(paddr_l), 64'(32'h0), "rst_paddr");
    chk(64'({pwrite_l, pwdata_l}), 64'(33'h0), "rst_pwrite_pwdata");
    chk(64'({rsp_err_l, rsp_rdata_l}), 64'(33'h0), "rst_rsp");
    chk(64'(pvalid_s), 64'(1'b0), "rst_pvalid_short");
    PRESETn = 1'b1; req_valid = 1'b0;
    @(posedge PCLK); #1;
    @(negedge PCLK);
    chk(64'(req_ready_l), 64'(1'b1), "rst_req_ready");
    chk(64'(pvalid_l), 64'(1'b0), "rst_no_transfer");
    @(posedge PCLK); #1;

    // directed transfers
    run_txn(32'h0000_1000, 1'b0, 32'h0, 32'hDEAD_BEEF, 2, 0, "load");
    run_txn(32'h0000_2004, 1'b1, 32'h5A5A_5A5A, 32'hFFFF_0000, 6, 0, "store_slow");
    sel = 1'b1;
    run_txn(32'h0000_3000, 1'b0, 32'h0, 32'hCAFE_F00D, 6, 3, "timeout");
    sel = 1'b0;
    run_txn(32'h0000_4008, 1'b0, 32'h0, 32'h1234_5678, 2, 3, "backpressure");
    sel = 1'b1;
    run_txn(32'h0000_500C, 1'b0, 32'h0, 32'hA5A5_0FF0, 4, 0, "pready_at_limit");
    run_txn(32'h0000_6010, 1'b1, 32'h0BAD_CAFE, 32'h7777_7777, 1, 1, "fast_store");
    sel = 1'b0;

    // reset asserted mid-ACCESS
    req_valid = 1'b1; req_addr = 32'h0000_7000; req_write = 1'b0; PREADY = 1'b0;
    @(posedge PCLK); #1;
    req_valid = 1'b0;
    @(negedge PCLK);
    chk(64'(pvalid_l), 64'(1'b1), "midrst_access");
    @(posedge PCLK); #1;
    PRESETn = 1'b0;
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    @(negedge PCLK);
    chk(64'(pvalid_l), 64'(1'b0), "midrst_pvalid");
    chk(64'(req_ready_l), 64'(1'b1), "midrst_req_ready");
    PREADY = 1'b1;
    repeat (2) begin
      @(negedge PCLK);
      chk(64'(rsp_valid_l), 64'(1'b0), "midrst_no_rsp");
    end
    PREADY = 1'b0;
    @(posedge PCLK); #1;

    // randomized transfers on either instance
    for (int i = 0; i < 24; i++) begin
      sel = 1'($urandom_range(0, 1));
      t   = sel ? T_SHORT : T_LONG;
      d   = $urandom_range(0, t + 2);
      rw  = $urandom_range(0, 3);
      w   = 1'($urandom_range(0, 1));
      a   = $urandom; wd = $urandom; rd = $urandom;
      run_txn(a, w, wd, rd, d, rw, "rand");
    end

    chk(64'(exp_q.size()), 64'(0), "scoreboard_empty");
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
